hazard_info_pipe: RTL and testbench

Producer side of the pipeline hazard interface. It carries each instruction's destination register, write enable, source registers and remaining result latency (Tnew) from the D stage through the E, M and W pipeline registers. Tnew counts down as the instruction advances. A bubble is inserted into E whenever the hazard unit asserts stall. The registered outputs are exactly the per-stage A1/A2/A3/WE/Tnew values that the forwarding/stall control unit consumes.

---
 rtl/hazard_info_pipe_if.sv | 39 +++
 rtl/hazard_info_pipe.sv | 91 +++++++++
 tb/tb_hazard_info_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_info_pipe_if.sv
// D-stage hazard fields in, per-stage E/M/W hazard fields out.
// stall_cnt exists only when HAZARD_PIPE_STAT_EN is defined.
interface hazard_info_pipe_if;
  logic       stall;
  logic [4:0] a1_d, a2_d, a3_d;
  logic       we_d;
  logic [2:0] tnew_d;
  logic [4:0] a1_e, a2_e, a3_e;
  logic       we_e;
  logic [2:0] tnew_e;
  logic [4:0] a1_m, a2_m, a3_m;
  logic       we_m;
  logic [2:0] tnew_m;
  logic [4:0] a3_w;
  logic       we_w;
`ifdef HAZARD_PIPE_STAT_EN
  logic [15:0] stall_cnt;
`endif

  modport master (
    output stall, a1_d, a2_d, a3_d, we_d, tnew_d,
    input  a1_e, a2_e, a3_e, we_e, tnew_e,
    input  a1_m, a2_m, a3_m, we_m, tnew_m,
    input  a3_w, we_w
`ifdef HAZARD_PIPE_STAT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  stall, a1_d, a2_d, a3_d, we_d, tnew_d,
    output a1_e, a2_e, a3_e, we_e, tnew_e,
    output a1_m, a2_m, a3_m, we_m, tnew_m,
    output a3_w, we_w
`ifdef HAZARD_PIPE_STAT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_info_pipe.sv
// Hazard-info shift pipeline D->E->M->W with a bubble mux on the E input.
// Optional stall-cycle counter enabled by defining HAZARD_PIPE_STAT_EN.
module hazard_info_pipe (
  input logic              clk,
  input logic              reset_n,
  hazard_info_pipe_if.slave bus
);

  function automatic logic [2:0] tnew_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

  logic [4:0] a1_p0, a2_p0, a3_p0;
  logic       we_p0;
  logic [2:0] tnew_p0;
  logic [4:0] a1_p1, a2_p1, a3_p1;
  logic       we_p1;
  logic [2:0] tnew_p1;
  logic [4:0] a3_p2;
  logic       we_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1_p0   <= '0;
      a2_p0   <= '0;
      a3_p0   <= '0;
      we_p0   <= 1'b0;
      tnew_p0 <= '0;
      a1_p1   <= '0;
      a2_p1   <= '0;
      a3_p1   <= '0;
      we_p1   <= 1'b0;
      tnew_p1 <= '0;
      a3_p2   <= '0;
      we_p2   <= 1'b0;
    end else begin
      // D -> E: a stall injects an all-zero bubble; writes to $0 are dropped here
      if (bus.stall) begin
        a1_p0   <= '0;
        a2_p0   <= '0;
        a3_p0   <= '0;
        we_p0   <= 1'b0;
        tnew_p0 <= '0;
      end else begin
        a1_p0   <= bus.a1_d;
        a2_p0   <= bus.a2_d;
        a3_p0   <= bus.a3_d;
        we_p0   <= bus.we_d && (bus.a3_d != 5'd0);
        tnew_p0 <= bus.tnew_d;
      end
      // E -> M
      a1_p1   <= a1_p0;
      a2_p1   <= a2_p0;
      a3_p1   <= a3_p0;
      we_p1   <= we_p0;
      tnew_p1 <= tnew_dec(tnew_p0);
      // M -> W
      a3_p2   <= a3_p1;
      we_p2   <= we_p1;
    end
  end

  assign bus.a1_e   = a1_p0;
  assign bus.a2_e   = a2_p0;
  assign bus.a3_e   = a3_p0;
  assign bus.we_e   = we_p0;
  assign bus.tnew_e = tnew_p0;
  assign bus.a1_m   = a1_p1;
  assign bus.a2_m   = a2_p1;
  assign bus.a3_m   = a3_p1;
  assign bus.we_m   = we_p1;
  assign bus.tnew_m = tnew_p1;
  assign bus.a3_w   = a3_p2;
  assign bus.we_w   = we_p2;

`ifdef HAZARD_PIPE_STAT_EN
  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       stall_cnt_q <= '0;
    else if (bus.stall) stall_cnt_q <= cnt_sat_inc(stall_cnt_q);
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Directed bench for hazard_info_pipe: history-based model checked every cycle,
// plus hand-computed literal expectations. Define HAZARD_PIPE_STAT_EN for the counter.
module tb_hazard_info_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hazard_info_pipe_if bus ();

  hazard_info_pipe dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a1, a2, a3, we, tnew;
  } entry_t;

  // hist[k] = what entered E (k+1) edges ago; bubbles and reset are all-zero entries
  entry_t hist[3];
  longint stall_edges = 0;

  initial for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0};
      stall_edges = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (bus.stall) begin
        hist[0] = '{0, 0, 0, 0, 0};
        stall_edges++;
      end else begin
        hist[0] = '{int'(bus.a1_d), int'(bus.a2_d), int'(bus.a3_d),
                    int'(bus.we_d), int'(bus.tnew_d)};
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wr(input entry_t e);
    return (e.we != 0 && e.a3 != 0) ? 1 : 0;
  endfunction

  bit model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      check("m_a1_e",   int'(bus.a1_e),   hist[0].a1);
      check("m_a2_e",   int'(bus.a2_e),   hist[0].a2);
      check("m_a3_e",   int'(bus.a3_e),   hist[0].a3);
      check("m_we_e",   int'(bus.we_e),   wr(hist[0]));
      check("m_tnew_e", int'(bus.tnew_e), hist[0].tnew);
      check("m_a1_m",   int'(bus.a1_m),   hist[1].a1);
      check("m_a2_m",   int'(bus.a2_m),   hist[1].a2);
      check("m_a3_m",   int'(bus.a3_m),   hist[1].a3);
      check("m_we_m",   int'(bus.we_m),   wr(hist[1]));
      check("m_tnew_m", int'(bus.tnew_m), (hist[1].tnew > 0) ? hist[1].tnew - 1 : 0);
      check("m_a3_w",   int'(bus.a3_w),   hist[2].a3);
      check("m_we_w",   int'(bus.we_w),   wr(hist[2]));
`ifdef HAZARD_PIPE_STAT_EN
      check("m_stall_cnt", int'(bus.stall_cnt),
            (stall_edges > 65535) ? 65535 : int'(stall_edges));
`endif
    end
  end

  task automatic cyc(input int a1, input int a2, input int a3, input int we,
                     input int tnew, input int st);
    bus.a1_d   = 5'(a1);
    bus.a2_d   = 5'(a2);
    bus.a3_d   = 5'(a3);
    bus.we_d   = 1'(we);
    bus.tnew_d = 3'(tnew);
    bus.stall  = 1'(st);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    int sum;
    sum = int'(bus.a1_e) + int'(bus.a2_e) + int'(bus.a3_e) + int'(bus.we_e)
        + int'(bus.tnew_e) + int'(bus.a1_m) + int'(bus.a2_m) + int'(bus.a3_m)
        + int'(bus.we_m) + int'(bus.tnew_m) + int'(bus.a3_w) + int'(bus.we_w);
`ifdef HAZARD_PIPE_STAT_EN
    sum += int'(bus.stall_cnt);
`endif
    check(tag, sum, 0);
  endtask

  initial begin
    bus.stall  = 1'($urandom);
    bus.a1_d   = 5'($urandom);
    bus.a2_d   = 5'($urandom);
    bus.a3_d   = 5'($urandom);
    bus.we_d   = 1'b1;
    bus.tnew_d = 3'($urandom);
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    model_on = 1'b1;
    reset_n = 1'b1;

    // reset release and latency
    cyc(1, 2, 8, 1, 2, 0);
    check("lat_a3_e", int'(bus.a3_e), 8);
    check("lat_we_e", int'(bus.we_e), 1);
    check("lat_tnew_e", int'(bus.tnew_e), 2);
    cyc(0, 0, 0, 0, 0, 0);
    check("lat_a3_m", int'(bus.a3_m), 8);
    check("lat_tnew_m", int'(bus.tnew_m), 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("lat_a3_w", int'(bus.a3_w), 8);
    check("lat_we_w", int'(bus.we_w), 1);

    // Tnew saturation
    cyc(3, 4, 1, 1, 0, 0);
    check("sat0_tnew_e", int'(bus.tnew_e), 0);
    cyc(5, 6, 2, 1, 7, 0);
    check("sat0_tnew_m", int'(bus.tnew_m), 0);
    check("sat7_tnew_e", int'(bus.tnew_e), 7);
    cyc(0, 0, 0, 0, 0, 0);
    check("sat7_tnew_m", int'(bus.tnew_m), 6);

    // $0 write is suppressed at every stage
    cyc(7, 7, 0, 1, 3, 0);
    check("r0_we_e", int'(bus.we_e), 0);
    cyc(9, 9, 10, 1, 1, 0);
    check("r0_we_m", int'(bus.we_m), 0);
    check("r0_a3_m", int'(bus.a3_m), 0);
    cyc(11, 11, 12, 1, 1, 0);
    check("r0_we_w", int'(bus.we_w), 0);

    // stall bubbles
    cyc(1, 1, 5, 1, 1, 0);
    check("st_a3_e_A", int'(bus.a3_e), 5);
    cyc(2, 3, 9, 1, 3, 1);
    check("st_a3_e_b1", int'(bus.a3_e), 0);
    check("st_we_e_b1", int'(bus.we_e), 0);
    check("st_tnew_e_b1", int'(bus.tnew_e), 0);
    check("st_a3_m_A", int'(bus.a3_m), 5);
    check("st_tnew_m_A", int'(bus.tnew_m), 0);
    cyc(2, 3, 9, 1, 3, 1);
    check("st_a3_e_b2", int'(bus.a3_e), 0);
    check("st_a3_m_b1", int'(bus.a3_m), 0);
    check("st_a3_w_A", int'(bus.a3_w), 5);
    cyc(2, 3, 9, 1, 3, 0);
    check("st_a3_e_rel", int'(bus.a3_e), 9);
    check("st_we_e_rel", int'(bus.we_e), 1);
    check("st_we_m_b2", int'(bus.we_m), 0);

    // asynchronous reset mid-stream
    cyc(0, 0, 3, 1, 2, 0);
    cyc(0, 0, 4, 1, 2, 0);
    cyc(0, 0, 6, 1, 2, 0);
    check("ar_a3_e", int'(bus.a3_e), 6);
    check("ar_a3_m", int'(bus.a3_m), 4);
    check("ar_a3_w", int'(bus.a3_w), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

`ifdef HAZARD_PIPE_STAT_EN
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 1, 1);
    check("cnt_5", int'(bus.stall_cnt), 5);
    for (int i = 0; i < 70000; i++) cyc(1, 1, 1, 1, 1, 1);
    check("cnt_sat", int'(bus.stall_cnt), 65535);
    cyc(1, 1, 1, 1, 1, 1);
    check("cnt_hold", int'(bus.stall_cnt), 65535);
    cyc(0, 0, 0, 0, 0, 0);
`endif

    cyc(0, 0, 0, 0, 0, 0);
    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
